// File: rtl/ps2_pkg.sv
// Shared types and constants for the PS/2 receive controller.
package ps2_pkg;

   // Receive FSM states: waiting for a start bit, shifting data, parity, stop.
   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_DATA   = 2'd1,
      ST_PARITY = 2'd2,
      ST_STOP   = 2'd3
   } ps2_state_t;

   // Start + 8 data + parity + stop.
   localparam int FRAME_BITS = 11;
   localparam int DATA_W     = 8;

   // Odd parity holds when the data bits and the parity bit together carry an odd number of ones.
   function automatic logic parity_ok(input logic [DATA_W-1:0] data, input logic parity);
      return ^{data, parity};
   endfunction

endpackage

// File: rtl/ps2_rx_fifo.sv
// Small synchronous FIFO holding received PS/2 bytes; head is shown combinationally.
module ps2_rx_fifo
   import ps2_pkg::*;
#(
   parameter int DEPTH = 4
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     push,
   input  logic [DATA_W-1:0]        push_data,
   input  logic                     pop,
   output logic [DATA_W-1:0]        pop_data,
   output logic                     full,
   output logic                     empty,
   output logic [$clog2(DEPTH):0]   count
);

   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;

   logic [DATA_W-1:0] mem [DEPTH];
   logic [AW-1:0]     wr_ptr;
   logic [AW-1:0]     rd_ptr;
   logic              do_push;
   logic              do_pop;

   assign full  = (count == CW'(DEPTH));
   assign empty = (count == '0);

   // A push into a full FIFO is only taken when the head leaves in the same cycle.
   assign do_push = push & (~full | pop);
   assign do_pop  = pop & ~empty;

   // Mask the head while empty so the output reads zero out of reset.
   assign pop_data = empty ? '0 : mem[rd_ptr];

   // Storage array: written on push only.
   // NOTE: the data array has no reset; the pointers and count alone define which entries are valid.
   always_ff @(posedge clk) begin
      if (do_push) begin
         mem[wr_ptr] <= push_data;
      end
   end

   // Pointer and occupancy bookkeeping; pointers wrap naturally because DEPTH is a power of two.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + 1'b1;
         if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
         case ({do_push, do_pop})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
      end
   end

endmodule

// File: rtl/ps2_rx_ctrl.sv
// PS/2 device-to-host receiver: synchronizes the lines, decodes 11-bit frames,
// buffers good bytes in a FIFO and holds the PS/2 clock off while that FIFO is full.
module ps2_rx_ctrl
   import ps2_pkg::*;
#(
   parameter int FIFO_DEPTH     = 4,
   parameter int TIMEOUT_CYCLES = 2000,
   parameter int SYNC_STAGES    = 2
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              ps2_clk_i,
   input  logic              ps2_dat_i,
   output logic              ps2_clk_inhibit,
   output logic [DATA_W-1:0] out_data,
   output logic              out_valid,
   input  logic              out_ready,
   output logic              err_parity,
   output logic              err_frame,
   output logic              err_timeout,
   output logic              err_overflow,
   output logic              busy
);

   localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;
   localparam int TO_W  = $clog2(TIMEOUT_CYCLES + 1);

   logic [SYNC_STAGES-1:0] clk_sync;
   logic [SYNC_STAGES-1:0] dat_sync;
   logic                   clk_prev;
   logic                   clk_s;
   logic                   dat_s;
   logic                   fall;

   ps2_state_t             state;
   logic [2:0]             bit_cnt;
   logic [DATA_W-1:0]      shift_reg;
   logic                   parity_bit;
   logic [TO_W-1:0]        timeout_cnt;

   logic                   pop;
   logic                   frame_good;
   logic                   push;
   logic                   fifo_full;
   logic                   fifo_empty;
   logic [CNT_W-1:0]       fifo_count;

   assign clk_s = clk_sync[SYNC_STAGES-1];
   assign dat_s = dat_sync[SYNC_STAGES-1];
   assign fall  = clk_prev & ~clk_s;

   assign pop        = out_valid & out_ready;
   assign frame_good = (state == ST_STOP) & fall & dat_s & parity_ok(shift_reg, parity_bit);
   assign push       = frame_good & (~fifo_full | pop);

   assign out_valid       = ~fifo_empty;
   assign busy            = (state != ST_IDLE);
   // Only throttle the device between frames; a frame already in flight is always completed.
   assign ps2_clk_inhibit = (fifo_count == CNT_W'(FIFO_DEPTH)) & (state == ST_IDLE);

   // Synchronizer chains for both asynchronous PS/2 lines plus the previous clock sample for edge detect.
   // NOTE: sequential state is assigned with <= so every flop samples the pre-edge values of its neighbours.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         clk_sync <= '1;
         dat_sync <= '1;
         clk_prev <= 1'b1;
      end else begin
         clk_sync <= {clk_sync[SYNC_STAGES-2:0], ps2_clk_i};
         dat_sync <= {dat_sync[SYNC_STAGES-2:0], ps2_dat_i};
         clk_prev <= clk_s;
      end
   end

   // Frame decoder FSM with inter-edge timeout and registered one-cycle error pulses.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state        <= ST_IDLE;
         bit_cnt      <= '0;
         shift_reg    <= '0;
         parity_bit   <= 1'b0;
         timeout_cnt  <= '0;
         err_parity   <= 1'b0;
         err_frame    <= 1'b0;
         err_timeout  <= 1'b0;
         err_overflow <= 1'b0;
      end else begin
         err_parity   <= 1'b0;
         err_frame    <= 1'b0;
         err_timeout  <= 1'b0;
         err_overflow <= 1'b0;

         if (state == ST_IDLE || fall) begin
            timeout_cnt <= '0;
         end else begin
            timeout_cnt <= timeout_cnt + 1'b1;
         end

         if (fall) begin
            case (state)
               ST_IDLE: begin
                  if (!dat_s) begin
                     state   <= ST_DATA;
                     bit_cnt <= '0;
                  end else begin
                     err_frame <= 1'b1;
                  end
               end
               ST_DATA: begin
                  shift_reg[bit_cnt] <= dat_s;
                  if (bit_cnt == 3'd7) begin
                     state <= ST_PARITY;
                  end else begin
                     bit_cnt <= bit_cnt + 3'd1;
                  end
               end
               ST_PARITY: begin
                  parity_bit <= dat_s;
                  state      <= ST_STOP;
               end
               ST_STOP: begin
                  state        <= ST_IDLE;
                  err_frame    <= ~dat_s;
                  err_parity   <= ~parity_ok(shift_reg, parity_bit);
                  err_overflow <= frame_good & fifo_full & ~pop;
               end
               default: state <= ST_IDLE;
            endcase
         end else if (state != ST_IDLE && timeout_cnt == TO_W'(TIMEOUT_CYCLES - 1)) begin
            state       <= ST_IDLE;
            bit_cnt     <= '0;
            err_timeout <= 1'b1;
         end
      end
   end

   ps2_rx_fifo #(
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk       (clk),
      .rst_n     (rst_n),
      .push      (push),
      .push_data (shift_reg),
      .pop       (pop),
      .pop_data  (out_data),
      .full      (fifo_full),
      .empty     (fifo_empty),
      .count     (fifo_count)
   );

endmodule

// File: tb/tb_ps2_rx_ctrl.sv
// Scoreboard bench for ps2_rx_ctrl: stimulus pushes expected bytes, a monitor pops and compares.
module tb_ps2_rx_ctrl;

   localparam int FIFO_DEPTH     = 4;
   localparam int TIMEOUT_CYCLES = 200;
   localparam int SYNC_STAGES    = 2;

   logic       clk = 1'b0;
   logic       rst_n;
   logic       ps2_clk;
   logic       ps2_dat;
   logic       ps2_clk_inhibit;
   logic [7:0] out_data;
   logic       out_valid;
   logic       out_ready;
   logic       err_parity, err_frame, err_timeout, err_overflow;
   logic       busy;

   int checks   = 0;
   int failures = 0;

   logic [7:0] exp_q [$];
   int  valid_cycles = 0;
   int  n_perr = 0, n_ferr = 0, n_terr = 0, n_oerr = 0;
   int  e_perr = 0, e_ferr = 0, e_terr = 0, e_oerr = 0;
   time last_fall_t = 0;
   time to_seen_t   = 0;
   int  vc_before;

   always #5 clk = ~clk;

   ps2_rx_ctrl #(
      .FIFO_DEPTH     (FIFO_DEPTH),
      .TIMEOUT_CYCLES (TIMEOUT_CYCLES),
      .SYNC_STAGES    (SYNC_STAGES)
   ) dut (
      .clk             (clk),
      .rst_n           (rst_n),
      .ps2_clk_i       (ps2_clk),
      .ps2_dat_i       (ps2_dat),
      .ps2_clk_inhibit (ps2_clk_inhibit),
      .out_data        (out_data),
      .out_valid       (out_valid),
      .out_ready       (out_ready),
      .err_parity      (err_parity),
      .err_frame       (err_frame),
      .err_timeout     (err_timeout),
      .err_overflow    (err_overflow),
      .busy            (busy)
   );

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic check_errs(input string tag);
      check({tag, "_err_parity"},   n_perr, e_perr);
      check({tag, "_err_frame"},    n_ferr, e_ferr);
      check({tag, "_err_timeout"},  n_terr, e_terr);
      check({tag, "_err_overflow"}, n_oerr, e_oerr);
   endtask

   // Monitor: compares every accepted byte against the scoreboard and tallies error pulses.
   always @(negedge clk) begin
      if (rst_n === 1'b1) begin
         if (out_valid) valid_cycles++;
         if (out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
               checks++;
               failures++;
               $display("FAIL unexpected_byte: got 0x%02h expected none", out_data);
            end else begin
               check("rx_byte", out_data, exp_q.pop_front());
            end
         end
         if (err_parity)   n_perr++;
         if (err_frame)    n_ferr++;
         if (err_overflow) n_oerr++;
         if (err_timeout) begin
            n_terr++;
            to_seen_t = $time;
         end
      end
   end

   // One PS/2 bit cell: data settles, clock low for 8 cycles, then high.
   task automatic ps2_bit(input logic b);
      ps2_dat = b;
      repeat (4) @(posedge clk);
      #1;
      ps2_clk     = 1'b0;
      last_fall_t = $time;
      repeat (8) @(posedge clk);
      #1;
      ps2_clk = 1'b1;
      repeat (4) @(posedge clk);
      #1;
   endtask

   task automatic send_frame(input logic [7:0] d, input logic par_flip, input logic stop);
      ps2_bit(1'b0);
      for (int i = 0; i < 8; i++) ps2_bit(d[i]);
      ps2_bit((~^d) ^ par_flip);
      ps2_bit(stop);
      ps2_dat = 1'b1;
   endtask

   task automatic send_good(input logic [7:0] d);
      exp_q.push_back(d);
      send_frame(d, 1'b0, 1'b1);
   endtask

   task automatic send_partial(input logic [7:0] d, input int nbits);
      ps2_bit(1'b0);
      for (int i = 0; i < nbits; i++) ps2_bit(d[i]);
      ps2_dat = 1'b1;
   endtask

   task automatic idle(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog expired");
   end

   initial begin
      rst_n     = 1'b0;
      ps2_clk   = 1'b1;
      ps2_dat   = 1'b1;
      out_ready = 1'b1;
      repeat (3) @(negedge clk);
      check("rst_out_valid", out_valid, 0);
      check("rst_out_data",  out_data, 0);
      check("rst_busy",      busy, 0);
      check("rst_inhibit",   ps2_clk_inhibit, 0);
      check("rst_errs",      {err_parity, err_frame, err_timeout, err_overflow}, 0);
      @(posedge clk);
      #1 rst_n = 1'b1;
      idle(5);

      // Single good frame, consumer always ready.
      vc_before = valid_cycles;
      send_good(8'hA5);
      idle(10);
      check("a5_valid_cycles", valid_cycles - vc_before, 1);
      check_errs("a5");

      // Sixteen frames back to back.
      for (int i = 0; i < 16; i++) send_good(8'(i));
      idle(10);
      check("b2b_queue_drained", exp_q.size(), 0);
      check_errs("b2b");

      // 0x3C has even weight, so a parity bit of 0 is the bad one.
      send_frame(8'h3C, 1'b1, 1'b1);
      idle(10);
      e_perr++;
      check_errs("bad_parity");
      send_frame(8'h3C, 1'b0, 1'b0);
      idle(10);
      e_ferr++;
      check_errs("bad_stop");

      // A falling edge with data high while idle is not a start bit.
      ps2_bit(1'b1);
      idle(10);
      e_ferr++;
      check_errs("false_start");
      check("false_start_busy", busy, 0);

      // Start plus five data bits, then silence.
      send_partial(8'h1F, 5);
      check("timeout_busy_mid", busy, 1);
      idle(TIMEOUT_CYCLES + 40);
      e_terr++;
      check_errs("timeout");
      check("timeout_latency", 32'(to_seen_t - last_fall_t),
            32'((SYNC_STAGES + 1 + TIMEOUT_CYCLES) * 10 + 4));
      check("timeout_busy_after", busy, 0);
      send_good(8'h12);
      idle(10);
      check_errs("after_timeout");

      // Fill the FIFO with the consumer stalled, then force an extra frame.
      out_ready = 1'b0;
      for (int i = 1; i <= 4; i++) send_good(8'(i));
      idle(5);
      check("full_inhibit", ps2_clk_inhibit, 1);
      check("full_head", out_data, 8'h01);
      check("full_busy", busy, 0);
      send_frame(8'h05, 1'b0, 1'b1);
      idle(5);
      e_oerr++;
      check_errs("overflow");
      check("overflow_inhibit", ps2_clk_inhibit, 1);
      out_ready = 1'b1;
      @(posedge clk);
      #1 out_ready = 1'b0;
      @(negedge clk);
      check("pop_inhibit", ps2_clk_inhibit, 0);
      check("pop_head", out_data, 8'h02);
      check("pop_valid", out_valid, 1);
      idle(3);
      check("stall_head_stable", out_data, 8'h02);
      out_ready = 1'b1;
      idle(10);
      check("drain_valid", out_valid, 0);

      // Reset in the middle of a frame.
      send_partial(8'h0F, 4);
      check("mid_reset_busy_before", busy, 1);
      rst_n = 1'b0;
      idle(3);
      rst_n = 1'b1;
      idle(2);
      check("mid_reset_busy_after", busy, 0);
      idle(TIMEOUT_CYCLES + 20);
      check_errs("mid_reset");
      send_good(8'h7E);
      idle(10);
      check_errs("after_reset");

      check("final_queue_empty", exp_q.size(), 0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
